// File: rtl/miriscv_rvfi_trace_fifo.sv
// RVFI retirement trace FIFO: one compact record per retired instruction,
// drained as four 32-bit beats over a valid/ready stream, with overflow tracking.
module miriscv_rvfi_trace_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic                      clk_i,
    input  logic                      aresetn_i,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      rvfi_valid_i,
    input  logic [63:0]               rvfi_order_i,
    input  logic [31:0]               rvfi_insn_i,
    input  logic                      rvfi_trap_i,
    input  logic                      rvfi_intr_i,
    input  logic [4:0]                rvfi_rd_addr_i,
    input  logic [31:0]               rvfi_rd_wdata_i,
    input  logic [31:0]               rvfi_pc_rdata_i,
    input  logic [3:0]                rvfi_mem_rmask_i,
    input  logic [3:0]                rvfi_mem_wmask_i,
    output logic                      trace_valid_o,
    output logic [31:0]               trace_data_o,
    output logic                      trace_last_o,
    input  logic                      trace_ready_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [DROP_W-1:0]         drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [31:0]       mem_pc    [DEPTH];
    logic [31:0]       mem_insn  [DEPTH];
    logic [31:0]       mem_wdata [DEPTH];
    logic [31:0]       mem_meta  [DEPTH];

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [LW-1:0]     level;
    logic [1:0]        beat;
    logic              ovf_pend;
    logic [DROP_W-1:0] drop_cnt;

    logic              empty;
    logic              full;
    logic              handshake;
    logic              pop;
    logic              attempt;
    logic              push;
    logic              drop;
    logic [31:0]       meta;
    logic              unused_order;

    assign unused_order = ^rvfi_order_i[63:16];

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign handshake = ~empty & trace_ready_i;
    assign pop       = handshake & (beat == 2'd3);
    assign attempt   = rvfi_valid_i & enable_i & ~flush_i;
    // A pop on this edge frees the head slot, so a full FIFO can still accept.
    assign push      = attempt & (~full | pop);
    assign drop      = attempt & ~push;

    assign meta = {rvfi_trap_i, rvfi_intr_i, ovf_pend, |rvfi_mem_rmask_i, |rvfi_mem_wmask_i,
                   rvfi_rd_addr_i, 6'b0, rvfi_order_i[15:0]};

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wptr]    <= rvfi_pc_rdata_i;
            mem_insn[wptr]  <= rvfi_insn_i;
            mem_wdata[wptr] <= rvfi_rd_wdata_i;
            mem_meta[wptr]  <= meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!aresetn_i || flush_i) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            beat     <= 2'd0;
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wptr     <= wptr + AW'(1);
                ovf_pend <= 1'b0;
            end
            if (drop) begin
                ovf_pend <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
            if (handshake) begin
                beat <= beat + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_comb begin
        trace_data_o = '0;
        if (!empty) begin
            case (beat)
                2'd0:    trace_data_o = mem_pc[rptr];
                2'd1:    trace_data_o = mem_insn[rptr];
                2'd2:    trace_data_o = mem_wdata[rptr];
                default: trace_data_o = mem_meta[rptr];
            endcase
        end
    end

    assign trace_valid_o = ~empty;
    assign trace_last_o  = ~empty & (beat == 2'd3);
    assign level_o       = level;
    assign full_o        = full;
    assign empty_o       = empty;
    assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_miriscv_rvfi_trace_fifo.sv
// Directed bench for miriscv_rvfi_trace_fifo (DEPTH=4, DROP_W=2): per-cycle vector
// table plus hand sequences for flush, saturation and mid-frame reset.
module tb_miriscv_rvfi_trace_fifo;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        flush;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic        trace_valid;
    logic [31:0] trace_data;
    logic        trace_last;
    logic        trace_ready;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic [1:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    miriscv_rvfi_trace_fifo #(
        .DEPTH  (4),
        .DROP_W (2)
    ) dut (
        .clk_i            (clk),
        .aresetn_i        (aresetn),
        .enable_i         (enable),
        .flush_i          (flush),
        .rvfi_valid_i     (rvfi_valid),
        .rvfi_order_i     (rvfi_order),
        .rvfi_insn_i      (rvfi_insn),
        .rvfi_trap_i      (rvfi_trap),
        .rvfi_intr_i      (rvfi_intr),
        .rvfi_rd_addr_i   (rvfi_rd_addr),
        .rvfi_rd_wdata_i  (rvfi_rd_wdata),
        .rvfi_pc_rdata_i  (rvfi_pc_rdata),
        .rvfi_mem_rmask_i (rvfi_mem_rmask),
        .rvfi_mem_wmask_i (rvfi_mem_wmask),
        .trace_valid_o    (trace_valid),
        .trace_data_o     (trace_data),
        .trace_last_o     (trace_last),
        .trace_ready_i    (trace_ready),
        .level_o          (level),
        .full_o           (full),
        .empty_o          (empty),
        .drop_cnt_o       (drop_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [15:0] order;
        logic        trap;
        logic        intr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
    } pay_t;

    typedef struct {
        logic        rv;
        int          p;
        logic        en;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        int          lev;
        int          drop;
    } vec_t;

    pay_t pays[4];
    vec_t vecs[$];

    task automatic add(input logic rv, input int p, input logic en, input logic rdy,
                       input logic ev, input logic [31:0] ed, input logic el,
                       input int lev, input int drop);
        vec_t v;
        v.rv = rv; v.p = p; v.en = en; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.lev = lev; v.drop = drop;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [31:0] ed,
                              input logic el, input int lev, input int drop);
        check({tag, ".valid"}, 32'(trace_valid), 32'(ev));
        check({tag, ".data"},  trace_data, ed);
        check({tag, ".last"},  32'(trace_last), 32'(el));
        check({tag, ".level"}, 32'(level), 32'(lev));
        check({tag, ".empty"}, 32'(empty), 32'(lev == 0));
        check({tag, ".full"},  32'(full), 32'(lev == 4));
        check({tag, ".drop"},  32'(drop_cnt), 32'(drop));
    endtask

    task automatic set_ret(input logic rv, input int p);
        rvfi_valid     = rv;
        rvfi_pc_rdata  = pays[p].pc;
        rvfi_insn      = pays[p].insn;
        rvfi_rd_wdata  = pays[p].wdata;
        rvfi_rd_addr   = pays[p].rd;
        rvfi_order     = {48'hFFFF_0000_ABCD, pays[p].order};
        rvfi_trap      = pays[p].trap;
        rvfi_intr      = pays[p].intr;
        rvfi_mem_rmask = pays[p].rmask;
        rvfi_mem_wmask = pays[p].wmask;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pays[0] = '{32'h8000_0000, 32'h0050_0093, 32'h0000_0005, 5'd1, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0};
        pays[1] = '{32'h8000_0010, 32'h0000_a103, 32'hdead_beef, 5'd0, 16'h1234, 1'b1, 1'b0, 4'hF, 4'h0};
        pays[2] = '{32'h0000_1000, 32'h0000_0013, 32'h0000_0000, 5'd0, 16'h0007, 1'b0, 1'b0, 4'h0, 4'h0};
        pays[3] = '{32'h0000_2000, 32'h0000_0013, 32'h1234_abcd, 5'd2, 16'h0008, 1'b0, 1'b0, 4'h0, 4'h3};

        // Single retirement, ready held high.
        add(1, 0, 1, 1, 1, 32'h8000_0000, 0, 1, 0);
        add(0, 0, 1, 1, 1, 32'h0050_0093, 0, 1, 0);
        add(0, 0, 1, 1, 1, 32'h0000_0005, 0, 1, 0);
        add(0, 0, 1, 1, 1, 32'h0040_0000, 1, 1, 0);
        add(0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        // Trapping load, ready toggling.
        add(1, 1, 1, 0, 1, 32'h8000_0010, 0, 1, 0);
        add(0, 1, 1, 1, 1, 32'h0000_a103, 0, 1, 0);
        add(0, 1, 1, 0, 1, 32'h0000_a103, 0, 1, 0);
        add(0, 1, 1, 1, 1, 32'hdead_beef, 0, 1, 0);
        add(0, 1, 1, 0, 1, 32'hdead_beef, 0, 1, 0);
        add(0, 1, 1, 1, 1, 32'h9000_1234, 1, 1, 0);
        add(0, 1, 1, 0, 1, 32'h9000_1234, 1, 1, 0);
        add(0, 1, 1, 1, 0, 32'h0, 0, 0, 0);
        // Capture disabled: no push, no drop.
        add(1, 0, 0, 1, 0, 32'h0, 0, 0, 0);
        // Overflow: fill, drop two, then push on the beat-3 handshake.
        for (int k = 1; k <= 4; k++) add(1, 2, 1, 0, 1, 32'h0000_1000, 0, k, 0);
        add(1, 2, 1, 0, 1, 32'h0000_1000, 0, 4, 1);
        add(1, 2, 1, 0, 1, 32'h0000_1000, 0, 4, 2);
        add(0, 2, 1, 1, 1, 32'h0000_0013, 0, 4, 2);
        add(0, 2, 1, 1, 1, 32'h0000_0000, 0, 4, 2);
        add(0, 2, 1, 1, 1, 32'h0000_0007, 1, 4, 2);
        add(1, 3, 1, 1, 1, 32'h0000_1000, 0, 4, 2);
        for (int r = 0; r < 3; r++) begin
            add(0, 0, 1, 1, 1, 32'h0000_0013, 0, 4 - r, 2);
            add(0, 0, 1, 1, 1, 32'h0000_0000, 0, 4 - r, 2);
            add(0, 0, 1, 1, 1, 32'h0000_0007, 1, 4 - r, 2);
            add(0, 0, 1, 1, 1, (r == 2) ? 32'h0000_2000 : 32'h0000_1000, 0, 3 - r, 2);
        end
        add(0, 0, 1, 1, 1, 32'h0000_0013, 0, 1, 2);
        add(0, 0, 1, 1, 1, 32'h1234_abcd, 0, 1, 2);
        add(0, 0, 1, 1, 1, 32'h2880_0008, 1, 1, 2);
        add(0, 0, 1, 1, 0, 32'h0, 0, 0, 2);

        aresetn = 1'b0; enable = 1'b1; flush = 1'b0; trace_ready = 1'b0;
        set_ret(1'b0, 0);
        step();
        step();
        check_outs("reset", 0, 32'h0, 0, 0, 0);
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            set_ret(vecs[i].rv, vecs[i].p);
            enable      = vecs[i].en;
            trace_ready = vecs[i].rdy;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el,
                       vecs[i].lev, vecs[i].drop);
        end
        enable = 1'b1;

        // Flush mid-record with a same-cycle retirement; drop count is 2 going in.
        trace_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_ret(1'b1, 1);
            step();
            check(.name("flush_fill.level"), .act(32'(level)), .exp(32'(k)));
        end
        set_ret(1'b0, 1);
        trace_ready = 1'b1;
        step();
        step();
        check("flush_pre.data", trace_data, 32'hdead_beef);
        set_ret(1'b1, 0);
        flush = 1'b1;
        step();
        check_outs("flush", 0, 32'h0, 0, 0, 0);
        flush = 1'b0;
        step();
        check_outs("post_flush", 1, 32'h8000_0000, 0, 1, 0);
        set_ret(1'b0, 0);
        step();
        check("post_flush.b1", trace_data, 32'h0050_0093);
        step();
        step();
        check("post_flush.b3", trace_data, 32'h0040_0000);
        step();
        check_outs("post_flush.end", 0, 32'h0, 0, 0, 0);

        // Saturating drops, then reset mid-frame.
        trace_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            set_ret(1'b1, 0);
            step();
            check_outs($sformatf("sat%0d", k), 1, 32'h8000_0000, 0, (k > 4) ? 4 : k,
                       (k <= 4) ? 0 : ((k - 4 > 3) ? 3 : k - 4));
        end
        set_ret(1'b0, 0);
        trace_ready = 1'b1;
        step();
        check("pre_reset.data", trace_data, 32'h0050_0093);
        aresetn = 1'b0;
        step();
        check_outs("mid_reset", 0, 32'h0, 0, 0, 0);
        aresetn = 1'b1;
        set_ret(1'b1, 0);
        step();
        check_outs("post_reset", 1, 32'h8000_0000, 0, 1, 0);
        set_ret(1'b0, 0);
        trace_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
